// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encodings and helpers for the keypad entry controller.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_STAR = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        HOLD    = 2'd2
    } state_t;

    typedef enum logic {
        WAIT_PRESS   = 1'b0,
        WAIT_RELEASE = 1'b1
    } trk_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'h9);
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Key input, operand handshake and entry status bundle between the keypad controller and its user.
interface keypad_entry_ctrl_if;

    logic [3:0]  key_code;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] operand_a;
    logic [11:0] operand_b;
    logic [11:0] display_bcd;
    logic [1:0]  digit_count;
    logic        entering_b;
    logic        err;

    modport master (
        output key_code, out_ready,
        input  out_valid, operand_a, operand_b, display_bcd, digit_count, entering_b, err
    );

    modport slave (
        input  key_code, out_ready,
        output out_valid, operand_a, operand_b, display_bcd, digit_count, entering_b, err
    );

endinterface

// File: rtl/key_event_detector.sv
// Press/release tracker: one key_evt pulse per stable press, re-armed only by a stable release.
module key_event_detector
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    output logic       key_evt,
    output logic [3:0] key_val
);

    localparam logic [15:0] STABLE_W = 16'(STABLE_CYCLES);

    trk_state_t  trk_q, trk_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  last_q, last_d;
    logic        evt_q, evt_d;
    logic [3:0]  val_q, val_d;

    // Run-length counter saturates so a long hold never re-fires; the state gates press vs release.
    always_comb begin
        trk_d  = trk_q;
        cnt_d  = cnt_q;
        last_d = key_code;
        evt_d  = 1'b0;
        val_d  = val_q;
        if (key_code != last_q) begin
            cnt_d = 16'd1;
        end else if (cnt_q != STABLE_W) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        case (trk_q)
            WAIT_PRESS: begin
                if ((cnt_d == STABLE_W) && (key_code != KEY_NONE)) begin
                    evt_d = 1'b1;
                    val_d = key_code;
                    trk_d = WAIT_RELEASE;
                end else begin
                    trk_d = WAIT_PRESS;
                end
            end
            WAIT_RELEASE: begin
                if ((cnt_d == STABLE_W) && (key_code == KEY_NONE)) begin
                    trk_d = WAIT_PRESS;
                end else begin
                    trk_d = WAIT_RELEASE;
                end
            end
            default: trk_d = WAIT_PRESS;
        endcase
    end

    // Tracker state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trk_q  <= WAIT_PRESS;
            cnt_q  <= 16'd0;
            last_q <= KEY_NONE;
            evt_q  <= 1'b0;
            val_q  <= 4'h0;
        end else begin
            trk_q  <= trk_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            evt_q  <= evt_d;
            val_q  <= val_d;
        end
    end

    assign key_evt = evt_q;
    assign key_val = val_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad operand entry: collects two 3-digit BCD operands and offers them with a valid/ready handshake.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    keypad_entry_ctrl_if.slave  bus
);

    logic       key_evt;
    logic [3:0] key_val;

    state_t      state_q, state_d;
    logic [11:0] disp_q, disp_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] opa_q, opa_d;
    logic [11:0] opb_q, opb_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    key_event_detector #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_det (
        .clk      (clk),
        .reset    (reset),
        .key_code (bus.key_code),
        .key_evt  (key_evt),
        .key_val  (key_val)
    );

    // Entry FSM: key events edit the operand being typed; HOLD only waits for the transfer.
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            ENTER_A, ENTER_B: begin
                if (!key_evt) begin
                    state_d = state_q;
                end else if (is_digit(key_val)) begin
                    if (cnt_q != 2'd3) begin
                        disp_d = {disp_q[7:0], key_val};
                        cnt_d  = cnt_q + 2'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    case (key_val)
                        KEY_A: begin
                            if ((state_q == ENTER_A) && (cnt_q != 2'd0)) begin
                                opa_d   = disp_q;
                                disp_d  = 12'h000;
                                cnt_d   = 2'd0;
                                state_d = ENTER_B;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        KEY_HASH: begin
                            if ((state_q == ENTER_B) && (cnt_q != 2'd0)) begin
                                opb_d   = disp_q;
                                valid_d = 1'b1;
                                state_d = HOLD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        KEY_STAR: begin
                            disp_d = 12'h000;
                            cnt_d  = 2'd0;
                        end
                        KEY_C: begin
                            disp_d  = 12'h000;
                            cnt_d   = 2'd0;
                            opa_d   = 12'h000;
                            opb_d   = 12'h000;
                            state_d = ENTER_A;
                        end
                        KEY_B:   err_d = 1'b1;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            HOLD: begin
                if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    opa_d   = 12'h000;
                    opb_d   = 12'h000;
                    disp_d  = 12'h000;
                    cnt_d   = 2'd0;
                    state_d = ENTER_A;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = ENTER_A;
        endcase
    end

    // Entry FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ENTER_A;
            disp_q  <= 12'h000;
            cnt_q   <= 2'd0;
            opa_q   <= 12'h000;
            opb_q   <= 12'h000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.operand_a   = opa_q;
    assign bus.operand_b   = opb_q;
    assign bus.display_bcd = disp_q;
    assign bus.digit_count = cnt_q;
    assign bus.entering_b  = (state_q == ENTER_B);
    assign bus.err         = err_q;

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4096, meaning the number of consecutive cycles key_code must hold a value for a press or release to be accepted (range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_code  input  4  registered scanner code: 0x0-0x9 digit, 0xA-0xC letters, 0xD '*', 0xE '#', 0xF no key.
REQ-005 SHALL have port out_ready  input  1  downstream accepts the operand pair.
REQ-006 SHALL have port out_valid  output  1  operand pair available.
REQ-007 SHALL have port operand_a  output  12  three-digit BCD operand A.
REQ-008 SHALL have port operand_b  output  12  three-digit BCD operand B.
REQ-009 SHALL have port display_bcd  output  12  BCD digits of the operand being entered.
REQ-010 SHALL have port digit_count  output  2  digits entered in the current operand (0..3).
REQ-011 SHALL have port entering_b  output  1  high while operand B is being entered.
REQ-012 SHALL have port err  output  1  one-cycle pulse on a rejected key.

Function
REQ-013 SHALL detect key events with a two-state tracker:
- WAIT_PRESS: a non-0xF code held unchanged for STABLE_CYCLES produces one key event, then moves to WAIT_RELEASE.
- WAIT_RELEASE: 0xF held for STABLE_CYCLES re-arms WAIT_PRESS.
- A code change restarts the count.
REQ-014 SHALL generate exactly one key event per press, no matter how long the key is held.
REQ-015 SHALL run the main FSM in the states ENTER_A, ENTER_B and HOLD, with entering_b = (state == ENTER_B).
REQ-016 SHALL handle a digit event in ENTER_A/ENTER_B as follows:
- digit_count < 3: display_bcd <= {display_bcd[7:0], digit} and digit_count increments, both on the cycle after the event.
- digit_count = 3: the digit is ignored and err pulses.
REQ-017 SHALL handle 0xA in ENTER_A as follows:
- digit_count >= 1: copy display_bcd to operand_a, clear display_bcd and digit_count, go to ENTER_B.
- digit_count = 0: err pulses.
REQ-018 SHALL handle 0xE ('#') in ENTER_B as follows:
- digit_count >= 1: copy display_bcd to operand_b, go to HOLD and assert out_valid on the next cycle.
- digit_count = 0: err pulses.
REQ-019 SHALL handle 0xD ('*') by clearing display_bcd and digit_count in the current entry state, with no state change.
REQ-020 SHALL handle 0xC by clearing display_bcd, digit_count, operand_a and operand_b and going to ENTER_A, from either entry state.
REQ-021 SHALL treat 0xB, 0xA in ENTER_B and 0xE in ENTER_A as rejected keys that pulse err.
REQ-022 SHALL, in HOLD, keep out_valid high and operand_a/operand_b stable until the transfer cycle (out_valid and out_ready both high).
REQ-023 SHALL, in HOLD, ignore all key events without pulsing err, while the tracker keeps running.
REQ-024 SHALL, on the cycle after the transfer, drop out_valid, clear operands, display_bcd and digit_count, and enter ENTER_A.
REQ-025 SHALL ignore out_ready outside HOLD.

Reset
REQ-026 SHALL, on reset, asynchronously set: state ENTER_A, tracker WAIT_PRESS with count 0, all outputs 0.
REQ-027 SHALL accept a key held across reset deassertion STABLE_CYCLES after release of reset.
REQ-028 SHALL abort any transfer in progress when reset asserts mid-HOLD, without completing the handshake.

Structure
REQ-029 SHALL take key-code constants (KEY_NONE=0xF, KEY_A, KEY_B, KEY_C, KEY_STAR=0xD, KEY_HASH=0xE) and the FSM state enum from the shared package keypad_pkg.
REQ-030 SHALL implement the press/release tracker as sub-module key_event_detector, which outputs key_evt (one-cycle pulse) and key_val[3:0].

Verification (STABLE_CYCLES=4)
REQ-031 SHALL cover this scenario: press 1,2,3 (each 4 cycles, then 0xF for 4 cycles), then 0xA -> operand_a=0x123, digit_count=0, entering_b=1.
REQ-032 SHALL cover this scenario: enter 4, then 5, then 0xE, with out_ready=0 for 10 cycles then 1 -> out_valid high 11 cycles, operand_b=0x045, then out_valid=0 and state ENTER_A.
REQ-033 SHALL cover this scenario: hold digit 7 for 200 cycles -> exactly one digit shifted in, display_bcd=0x007.
REQ-034 SHALL cover this scenario: four digits 9,8,7,6 -> display_bcd=0x987 and one err pulse on the fourth digit.
REQ-035 SHALL cover this scenario: 0xE with digit_count=0 in ENTER_B -> err pulse, no out_valid; 0xC -> operand_a=0, entering_b=0.
REQ-036 SHALL cover this scenario: glitch code 5 for 3 cycles then 0xF -> no event; reset asserted in HOLD -> out_valid=0 immediately.
